// File: rtl/alu_datapath.sv
// A/B operand registers, add/subtract ALU, bus output mux and carry/zero flags.
// Optional ALU_SIGNED_OVF_EN adds the flag_v port and signed-overflow register.
module alu_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ai,
    input  logic             bi,
    input  logic             ao,
    input  logic             eo,
    input  logic             su,
    input  logic             fi,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_out_en,
    output logic [WIDTH-1:0] reg_a,
    output logic             flag_c,
`ifdef ALU_SIGNED_OVF_EN
    output logic             flag_v,
`endif
    output logic             flag_z
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   alu_ext;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_carry;
    logic             alu_zero;

    // Bit WIDTH of the extended subtraction is set exactly when A < B, so it doubles as borrow.
    always_comb begin
        alu_ext   = '0;
        if (su) begin
            alu_ext = {1'b0, a_q} - {1'b0, b_q};
        end else begin
            alu_ext = {1'b0, a_q} + {1'b0, b_q};
        end
        alu_sum   = alu_ext[MSB:0];
        alu_carry = alu_ext[WIDTH];
        alu_zero  = (alu_sum == '0);
    end

    // Result has priority over A when both drivers are requested.
    always_comb begin
        bus_out = '0;
        if (eo) begin
            bus_out = alu_sum;
        end else if (ao) begin
            bus_out = a_q;
        end
        bus_out_en = ao | eo;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (ai) a_q <= bus_in;
            if (bi) b_q <= bus_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (fi) begin
            flag_c <= alu_carry;
            flag_z <= alu_zero;
        end
    end

`ifdef ALU_SIGNED_OVF_EN
    logic alu_ovf;

    // Add overflows on like-signed operands; subtract on unlike-signed ones; both when the sign flips from A.
    always_comb begin
        alu_ovf = 1'b0;
        if (su) begin
            alu_ovf = (a_q[MSB] != b_q[MSB]) && (alu_sum[MSB] != a_q[MSB]);
        end else begin
            alu_ovf = (a_q[MSB] == b_q[MSB]) && (alu_sum[MSB] != a_q[MSB]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flag_v <= 1'b0;
        end else if (fi) begin
            flag_v <= alu_ovf;
        end
    end
`endif

    assign reg_a = a_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath; covers the V flag when ALU_SIGNED_OVF_EN is defined.
module tb_alu_datapath;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             n_rst;
    logic [WIDTH-1:0] bus_in;
    logic             ai, bi, ao, eo, su, fi;
    logic [WIDTH-1:0] bus_out;
    logic             bus_out_en;
    logic [WIDTH-1:0] reg_a;
    logic             flag_c;
    logic             flag_z;
`ifdef ALU_SIGNED_OVF_EN
    logic             flag_v;
`endif

    int total;
    int bad;

    alu_datapath #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bus_in     (bus_in),
        .ai         (ai),
        .bi         (bi),
        .ao         (ao),
        .eo         (eo),
        .su         (su),
        .fi         (fi),
        .bus_out    (bus_out),
        .bus_out_en (bus_out_en),
        .reg_a      (reg_a),
        .flag_c     (flag_c),
`ifdef ALU_SIGNED_OVF_EN
        .flag_v     (flag_v),
`endif
        .flag_z     (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [WIDTH-1:0] v);
        bus_in = v; ai = 1'b1;
        tick();
        ai = 1'b0;
    endtask

    task automatic load_b(input logic [WIDTH-1:0] v);
        bus_in = v; bi = 1'b1;
        tick();
        bi = 1'b0;
    endtask

    // Set A/B, check the live result, latch flags on one edge, then release the controls.
    task automatic alu_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic [WIDTH-1:0] exp_sum,
                          input logic exp_c, input logic exp_z);
        load_a(a);
        load_b(b);
        su = sub; eo = 1'b1; fi = 1'b1;
        #1;
        chk({tag, "_sum"}, 32'(bus_out), 32'(exp_sum));
        chk({tag, "_en"}, 32'(bus_out_en), 32'd1);
        tick();
        eo = 1'b0; fi = 1'b0;
        chk({tag, "_c"}, 32'(flag_c), 32'(exp_c));
        chk({tag, "_z"}, 32'(flag_z), 32'(exp_z));
    endtask

    initial begin
        total = 0; bad = 0;
        n_rst = 1'b0; bus_in = '0;
        ai = 1'b0; bi = 1'b0; ao = 1'b0; eo = 1'b0; su = 1'b0; fi = 1'b0;
        #12;
        chk("rst_reg_a", 32'(reg_a), 32'd0);
        chk("rst_c", 32'(flag_c), 32'd0);
        chk("rst_z", 32'(flag_z), 32'd0);
        chk("rst_bus", 32'(bus_out), 32'd0);
        chk("rst_en", 32'(bus_out_en), 32'd0);
        tick();
        n_rst = 1'b1;

        alu_op("add_10_20", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);
        alu_op("add_200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0);
        alu_op("add_0_0", 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle while A and Z hold non-zero values
        load_a(8'd55);
        chk("pre_rst_a", 32'(reg_a), 32'd55);
        chk("pre_rst_z", 32'(flag_z), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_a", 32'(reg_a), 32'd0);
        chk("async_rst_z", 32'(flag_z), 32'd0);
        chk("async_rst_c", 32'(flag_c), 32'd0);
        tick();
        n_rst = 1'b1;

        alu_op("sub_30_20", 8'd30, 8'd20, 1'b1, 8'd10, 1'b0, 1'b0);
        alu_op("sub_200_201", 8'd200, 8'd201, 1'b1, 8'd255, 1'b1, 1'b0);
        alu_op("sub_5_5", 8'd5, 8'd5, 1'b1, 8'd0, 1'b0, 1'b1);

        // Bus priority: eo beats ao
        load_a(8'd3);
        load_b(8'd4);
        su = 1'b0; ao = 1'b1; eo = 1'b1;
        #1;
        chk("prio_both", 32'(bus_out), 32'd7);
        eo = 1'b0;
        #1;
        chk("prio_ao", 32'(bus_out), 32'd3);
        chk("prio_ao_en", 32'(bus_out_en), 32'd1);
        ao = 1'b0;
        #1;
        chk("idle_bus", 32'(bus_out), 32'd0);

        // Loop-back: A <= A+B with flags of that sum (Z was 1 from 5-5)
        eo = 1'b1; ai = 1'b1; fi = 1'b1; bus_in = 8'd7;
        tick();
        eo = 1'b0; ai = 1'b0; fi = 1'b0;
        chk("loop_a", 32'(reg_a), 32'd7);
        chk("loop_z", 32'(flag_z), 32'd0);
        chk("loop_c", 32'(flag_c), 32'd0);

        // Flags hold with fi low even though live result would set C and Z
        load_b(8'd249);
        tick();
        chk("hold_c", 32'(flag_c), 32'd0);
        chk("hold_z", 32'(flag_z), 32'd0);

        // ai and fi together: flags from old A (7+249=256), A takes new value
        bus_in = 8'd1; ai = 1'b1; fi = 1'b1;
        tick();
        ai = 1'b0; fi = 1'b0;
        chk("aifi_a", 32'(reg_a), 32'd1);
        chk("aifi_c", 32'(flag_c), 32'd1);
        chk("aifi_z", 32'(flag_z), 32'd1);

`ifdef ALU_SIGNED_OVF_EN
        alu_op("ovf_add", 8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b0);
        chk("ovf_add_v", 32'(flag_v), 32'd1);
        alu_op("ovf_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b0);
        chk("ovf_sub_v", 32'(flag_v), 32'd1);
        alu_op("noovf_add", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);
        chk("noovf_add_v", 32'(flag_v), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
